// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light controller and its monitor:
// phase encoding, lamp constants, default dwell times and the phase successor.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GR = 2'b00,
    PH_YR = 2'b01,
    PH_RG = 2'b10,
    PH_RY = 2'b11
  } phase_t;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic [2:0] l1;
    logic [2:0] l2;
  } lamp_pair_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int GR_CYC_DEF = 51;
  localparam int YR_CYC_DEF = 6;
  localparam int RG_CYC_DEF = 36;
  localparam int RY_CYC_DEF = 6;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_GR:   n = PH_YR;
      PH_YR:   n = PH_RG;
      PH_RG:   n = PH_RY;
      default: n = PH_GR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_phase_decoder.sv
// Combinational decode of the two lamp buses into an intersection phase.
module traffic_phase_decoder
  import traffic_pkg::*;
(
  input  logic [2:0] light_1,
  input  logic [2:0] light_2,
  output logic [1:0] phase,
  output logic       valid
);

  always_comb begin
    phase = PH_GR;
    valid = 1'b1;
    case ({light_1, light_2})
      {GRN, RED}: phase = PH_GR;
      {YEL, RED}: phase = PH_YR;
      {RED, GRN}: phase = PH_RG;
      {RED, YEL}: phase = PH_RY;
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the two-approach light bus: tracks phase order and dwell,
// pulses encoding/sequence/duration errors and keeps a saturating error count.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GR_CYC = GR_CYC_DEF,
  parameter int YR_CYC = YR_CYC_DEF,
  parameter int RG_CYC = RG_CYC_DEF,
  parameter int RY_CYC = RY_CYC_DEF,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_1,
  input  logic [2:0] light_2,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_enc,
  output logic       err_seq,
  output logic       err_dur,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  function automatic logic [CNT_W-1:0] req_cyc(input phase_t p);
    logic [CNT_W-1:0] r;
    case (p)
      PH_GR:   r = CNT_W'(GR_CYC);
      PH_YR:   r = CNT_W'(YR_CYC);
      PH_RG:   r = CNT_W'(RG_CYC);
      default: r = CNT_W'(RY_CYC);
    endcase
    return r;
  endfunction

  lamp_pair_t       smp;
  logic             smp_vld;
  logic [1:0]       smp_ph_raw;
  phase_t           smp_ph;
  logic             smp_legal;

  mon_state_t       state;
  phase_t           cur_ph;
  phase_t           last_ph;
  logic             last_vld;
  logic [CNT_W-1:0] dwell;
  logic             ovr;

  logic [CNT_W-1:0] req_cur;
  logic [CNT_W-1:0] dwell_inc;
  logic             boundary;
  logic             e_enc, e_seq, e_dur;

  // smp_vld masks the reset value of the sample register (100/100 is illegal)
  // so that leaving reset never reports a spurious encoding error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp     <= '{l1: RED, l2: RED};
      smp_vld <= 1'b0;
    end else begin
      smp     <= '{l1: light_1, l2: light_2};
      smp_vld <= 1'b1;
    end
  end

  traffic_phase_decoder u_dec (
    .light_1 (smp.l1),
    .light_2 (smp.l2),
    .phase   (smp_ph_raw),
    .valid   (smp_legal)
  );

  assign smp_ph = phase_t'(smp_ph_raw);

  always_comb begin
    req_cur   = req_cyc(cur_ph);
    dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + 1'b1;
    boundary  = smp_vld && smp_legal && last_vld && (smp_ph != last_ph);
    e_enc     = smp_vld && !smp_legal;
    e_seq     = 1'b0;
    e_dur     = 1'b0;
    if (smp_vld && smp_legal && state == ST_TRACK) begin
      if (smp_ph == cur_ph) begin
        e_dur = !ovr && (dwell_inc == req_cur + 1'b1);
      end else begin
        e_seq = (smp_ph != next_phase(cur_ph));
        e_dur = !ovr && (dwell < req_cur);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ACQUIRE;
      cur_ph    <= PH_GR;
      last_ph   <= PH_GR;
      last_vld  <= 1'b0;
      dwell     <= '0;
      ovr       <= 1'b0;
      locked    <= 1'b0;
      err_enc   <= 1'b0;
      err_seq   <= 1'b0;
      err_dur   <= 1'b0;
      err_count <= '0;
    end else begin
      err_enc <= e_enc;
      err_seq <= e_seq;
      err_dur <= e_dur;
      if ((e_enc || e_seq || e_dur) && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
      if (smp_vld) begin
        if (!smp_legal) begin
          state  <= ST_ACQUIRE;
          locked <= 1'b0;
        end else begin
          last_ph  <= smp_ph;
          last_vld <= 1'b1;
          if (state == ST_TRACK && smp_ph == cur_ph) begin
            dwell <= dwell_inc;
            if (e_dur) ovr <= 1'b1;
          end else if (boundary) begin
            // Any boundary (even after a sequence error) starts a fully checked phase.
            cur_ph <= smp_ph;
            dwell  <= CNT_W'(1);
            ovr    <= 1'b0;
            state  <= ST_TRACK;
            locked <= 1'b1;
          end
        end
      end
    end
  end

  assign phase = cur_ph;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench: lamp sequences scored by a run-length model of the monitor rules.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] light_1 = 3'b100;
  logic [2:0] light_2 = 3'b100;
  logic [1:0] phase;
  logic       locked, err_enc, err_seq, err_dur;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .light_1   (light_1),
    .light_2   (light_2),
    .phase     (phase),
    .locked    (locked),
    .err_enc   (err_enc),
    .err_seq   (err_seq),
    .err_dur   (err_dur),
    .err_count (err_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int REQ [4] = '{51, 6, 36, 6};

  logic [5:0] stim[$];
  int x_enc[], x_seq[], x_dur[], x_lk[], x_ph[], x_cnt[];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] pair(input int p);
    case (p)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      2:       return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction

  function automatic int decode(input logic [5:0] v);
    for (int p = 0; p < 4; p++)
      if (pair(p) == v) return p;
    return -1;
  endfunction

  task automatic add(input int p, input int n);
    repeat (n) stim.push_back(pair(p));
  endtask

  task automatic add_raw(input logic [5:0] v, input int n);
    repeat (n) stim.push_back(v);
  endtask

  task automatic add_bad(input int n);
    logic [5:0] v;
    do v = 6'($urandom_range(0, 63)); while (decode(v) >= 0);
    add_raw(v, n);
  endtask

  // Walk the stimulus as maximal runs of identical lamp pairs; a tracked run's
  // errors land on its first sample (boundary) or its (req+1)th sample (overrun).
  task automatic build_model();
    int n, s, len, p, lp, lk, ph, prev_len, c;
    n = stim.size();
    x_enc = new[n]; x_seq = new[n]; x_dur = new[n];
    x_lk  = new[n]; x_ph  = new[n]; x_cnt = new[n];
    lk = 0; lp = -1; ph = 0; prev_len = 0; s = 0;
    while (s < n) begin
      len = 1;
      while (s + len < n && stim[s+len] == stim[s]) len++;
      p = decode(stim[s]);
      if (p < 0) begin
        lk = 0;
        for (int t = s; t < s + len; t++) x_enc[t] = 1;
      end else begin
        if (lp >= 0 && p != lp) begin
          if (lk != 0) begin
            x_seq[s] = (p != (ph + 1) % 4) ? 1 : 0;
            x_dur[s] = (prev_len < REQ[ph]) ? 1 : 0;
          end
          lk = 1; ph = p; prev_len = len;
          if (len > REQ[p] && s + REQ[p] < n) x_dur[s + REQ[p]] = 1;
        end
        lp = p;
      end
      for (int t = s; t < s + len; t++) begin
        x_lk[t] = lk;
        x_ph[t] = ph;
      end
      s += len;
    end
    c = 0;
    for (int t = 0; t < n; t++) begin
      if ((x_enc[t] | x_seq[t] | x_dur[t]) != 0 && c < 255) c++;
      x_cnt[t] = c;
    end
  endtask

  task automatic run_scn();
    int n;
    n = stim.size();
    build_model();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_errs", int'({err_enc, err_seq, err_dur}), 0);
    chk("rst_count", int'(err_count), 0);
    @(negedge clk);
    reset = 1'b0;
    {light_1, light_2} = stim[0];
    for (int t = 1; t <= n + 1; t++) begin
      @(negedge clk);
      cyc++;
      if (t == 1) begin
        chk("init_locked", int'(locked), 0);
        chk("init_errs", int'({err_enc, err_seq, err_dur}), 0);
        chk("init_count", int'(err_count), 0);
      end else begin
        chk("phase", int'(phase), x_ph[t-2]);
        chk("locked", int'(locked), x_lk[t-2]);
        chk("err_enc", int'(err_enc), x_enc[t-2]);
        chk("err_seq", int'(err_seq), x_seq[t-2]);
        chk("err_dur", int'(err_dur), x_dur[t-2]);
        chk("err_count", int'(err_count), x_cnt[t-2]);
      end
      if (t < n) {light_1, light_2} = stim[t];
    end
    stim.delete();
  endtask

  task automatic gen_random();
    int p, np, len, a;
    p = $urandom_range(0, 3);
    add(p, $urandom_range(1, 20));
    repeat (8) begin
      np = (p + 1) % 4;
      if ($urandom_range(0, 7) == 0) np = (p + 2) % 4;
      len = REQ[np];
      if ($urandom_range(0, 3) == 0) len = len + $urandom_range(0, 6) - 3;
      if (len < 1) len = 1;
      if ($urandom_range(0, 9) == 0 && len > 2) begin
        a = $urandom_range(1, len - 1);
        add(np, a);
        add_bad($urandom_range(1, 3));
        add(np, len - a);
      end else begin
        add(np, len);
      end
      p = np;
    end
  endtask

  initial begin
    // clean: partial GR, then three full cycles
    add(0, 20); add(1, 6); add(2, 36); add(3, 6);
    repeat (3) begin add(0, 51); add(1, 6); add(2, 36); add(3, 6); end
    add(0, 10);
    run_scn();

    // underrun: YR held 5
    add(3, 5); add(0, 51); add(1, 5); add(2, 36); add(3, 6); add(0, 5);
    run_scn();

    // overrun: RG held 40
    add(1, 3); add(2, 40); add(3, 6); add(0, 51); add(1, 2);
    run_scn();

    // bad sequence: GR -> RG
    add(3, 4); add(0, 51); add(2, 36); add(3, 6); add(0, 3);
    run_scn();

    // illegal lamps mid-RG
    add(3, 2); add(0, 51); add(1, 6); add(2, 10); add_raw(6'b011_100, 1);
    add(2, 26); add(3, 6); add(0, 51); add(1, 3);
    run_scn();

    // saturation: 300 illegal samples
    add(0, 3); add_raw(6'b011_100, 300);
    run_scn();
    chk("sat_count", int'(err_count), 255);

    repeat (4) begin
      gen_random();
      run_scn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
